// File: rtl/comparator_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } result_t;

  localparam result_t RES_NONE = 3'b000;
  localparam result_t RES_EQ   = 3'b100;
  localparam result_t RES_GT   = 3'b010;
  localparam result_t RES_LT   = 3'b001;

  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Digit counter width: max(1, clog2(ndig)).
  function automatic int unsigned cnt_width(input int unsigned ndig);
    if (ndig <= 2) return 1;
    return $clog2(ndig);
  endfunction

endpackage

// File: rtl/comparator_ds_seq_if.sv
// Operand/result handshake bundle for the digit-serial comparator.
interface comparator_ds_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  logic             busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, eq, gt, lt, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, eq, gt, lt, busy
  );
endinterface

// File: rtl/comparator_ds_seq_cmp_digit.sv
// One-digit magnitude compare: prefix-equality chain with MSB-priority greater.
module cmp_digit #(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  output logic             d_eq,
  output logic             d_gt
);

  logic [DIGIT:0]   eq_pre;
  logic [DIGIT-1:0] gt_bit;

  // eq_pre[i+1] = all bits above i match; a bit may only decide gt under that prefix.
  always_comb begin
    eq_pre         = '0;
    gt_bit         = '0;
    eq_pre[DIGIT]  = 1'b1;
    for (int i = int'(DIGIT) - 1; i >= 0; i--) begin
      eq_pre[i] = eq_pre[i+1] & ~(da[i] ^ db[i]);
      gt_bit[i] = eq_pre[i+1] & da[i] & ~db[i];
    end
  end

  assign d_eq = eq_pre[0];
  assign d_gt = |gt_bit;

endmodule

// File: rtl/comparator_ds_seq.sv
// Digit-serial magnitude comparator: latches operands, scans DIGIT bits per cycle MSB first.
module comparator_ds_seq
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIGIT      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  comparator_ds_seq_if.slave  bus
);

  localparam int unsigned NDIG = num_digits(WIDTH, DIGIT);
  localparam int unsigned CW   = cnt_width(NDIG);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("comparator_ds_seq: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  result_t          res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic d_eq, d_gt, d_lt;
  logic diff_seen;
  logic last_digit;

  // Operands are shifted left each SCAN cycle, so the current digit is always on top.
  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .da   (a_q[WIDTH-1 -: DIGIT]),
    .db   (b_q[WIDTH-1 -: DIGIT]),
    .d_eq (d_eq),
    .d_gt (d_gt)
  );

  assign d_lt       = ~d_eq & ~d_gt;
  assign diff_seen  = res_q.gt | res_q.lt;
  assign last_digit = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Signed mode flips the sign bit so an unsigned scan orders two's-complement values.
          a_d     = {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
          b_d     = {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
          cnt_d   = '0;
          res_d   = RES_NONE;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + CW'(1);
        if (!diff_seen && !d_eq) begin
          res_d = '{eq: 1'b0, gt: d_gt, lt: d_lt};
        end
        if (last_digit || (EARLY_EXIT && !d_eq)) begin
          if (!diff_seen && d_eq) begin
            res_d = RES_EQ;
          end
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      res_q       <= RES_NONE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.eq        = res_q.eq;
  assign bus.gt        = res_q.gt;
  assign bus.lt        = res_q.lt;

endmodule

// File: tb/tb_comparator_ds_seq.sv
// Bench for comparator_ds_seq: three configurations checked every cycle against a transaction-level model.
module tb_comparator_ds_seq;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv32  = 1'b0;
  logic        sm32  = 1'b0;
  logic [31:0] a32   = '0;
  logic [31:0] b32   = '0;
  logic        iv8   = 1'b0;
  logic        sm8   = 1'b0;
  logic [7:0]  a8    = '0;
  logic [7:0]  b8    = '0;
  logic        ordy  = 1'b1;

  always #5 clk = ~clk;

  comparator_ds_seq_if #(.WIDTH(32)) if0 ();
  comparator_ds_seq_if #(.WIDTH(32)) if1 ();
  comparator_ds_seq_if #(.WIDTH(8))  if2 ();

  assign if0.in_valid = iv32;  assign if0.a = a32;  assign if0.b = b32;
  assign if0.signed_mode = sm32;  assign if0.out_ready = ordy;
  assign if1.in_valid = iv32;  assign if1.a = a32;  assign if1.b = b32;
  assign if1.signed_mode = sm32;  assign if1.out_ready = ordy;
  assign if2.in_valid = iv8;   assign if2.a = a8;   assign if2.b = b8;
  assign if2.signed_mode = sm8;   assign if2.out_ready = ordy;

  comparator_ds_seq #(.WIDTH(32), .DIGIT(8), .EARLY_EXIT(1'b1)) u_ee (.clk(clk), .rst_n(rst_n), .bus(if0));
  comparator_ds_seq #(.WIDTH(32), .DIGIT(8), .EARLY_EXIT(1'b0)) u_full (.clk(clk), .rst_n(rst_n), .bus(if1));
  comparator_ds_seq #(.WIDTH(8),  .DIGIT(8), .EARLY_EXIT(1'b1)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model: per DUT, 0 = idle, 1 = scanning (mcnt cycles left), 2 = result held.
  int         phase [3];
  int         mcnt  [3];
  logic [2:0] er    [3];

  function automatic logic get_ov(input int d);
    case (d)
      0:       return if0.out_valid;
      1:       return if1.out_valid;
      default: return if2.out_valid;
    endcase
  endfunction

  function automatic logic get_ir(input int d);
    case (d)
      0:       return if0.in_ready;
      1:       return if1.in_ready;
      default: return if2.in_ready;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic [2:0] get_res(input int d);
    case (d)
      0:       return {if0.eq, if0.gt, if0.lt};
      1:       return {if1.eq, if1.gt, if1.lt};
      default: return {if2.eq, if2.gt, if2.lt};
    endcase
  endfunction

  // Expected result from integer values, and number of digits the scan must examine.
  function automatic void predict(input logic [31:0] a, input logic [31:0] b, input logic sm,
                                  input int w, input bit ee, output logic [2:0] res, output int m);
    logic [31:0] mask;
    longint      va;
    longint      vb;
    int          nd;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    va   = longint'({32'd0, a & mask});
    vb   = longint'({32'd0, b & mask});
    if (sm && a[w-1]) va = va - (longint'(1) << w);
    if (sm && b[w-1]) vb = vb - (longint'(1) << w);
    res = (va == vb) ? EQ : ((va > vb) ? GT : LT);
    nd  = w / 8;
    m   = nd;
    if (ee) begin
      for (int k = 0; k < nd; k++) begin
        if (((a >> (w - 8 * (k + 1))) & 32'hFF) != ((b >> (w - 8 * (k + 1))) & 32'hFF)) begin
          m = k + 1;
          break;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock: update the model on the rising edge, compare on the falling edge.
  task automatic cycle();
    logic [2:0] r;
    int         m;
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        phase[d] = 0;
        er[d]    = 3'b000;
      end else begin
        case (phase[d])
          0: begin
            if ((d < 2) ? iv32 : iv8) begin
              if (d < 2) predict(a32, b32, sm32, 32, (d == 0), r, m);
              else       predict({24'd0, a8}, {24'd0, b8}, sm8, 8, 1'b1, r, m);
              er[d]    = r;
              mcnt[d]  = m;
              phase[d] = 1;
            end
          end
          1: begin
            mcnt[d]--;
            if (mcnt[d] == 0) phase[d] = 2;
          end
          default: if (ordy) phase[d] = 0;
        endcase
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("in_ready[%0d]", d),  64'(get_ir(d)),   64'(phase[d] == 0));
      check($sformatf("busy[%0d]", d),      64'(get_busy(d)), 64'(phase[d] != 0));
      check($sformatf("out_valid[%0d]", d), 64'(get_ov(d)),   64'(phase[d] == 2));
      if (phase[d] == 2) check($sformatf("result[%0d]", d), 64'(get_res(d)), 64'(er[d]));
    end
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic sm, output int t0);
    a32 = a; b32 = b; sm32 = sm; iv32 = 1'b1;
    t0 = cyc;
    cycle();
    iv32 = 1'b0;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sm, output int t0);
    a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
    t0 = cyc;
    cycle();
    iv8 = 1'b0;
  endtask

  task automatic wait_result(input int d, input int t0, input int lat, input logic [2:0] res, input string name);
    int n = 0;
    while (!get_ov(d) && n < 40) begin
      cycle();
      n++;
    end
    check({name, "_valid"},   64'(get_ov(d)),  64'd1);
    check({name, "_latency"}, 64'(cyc - t0),   64'(lat));
    check({name, "_result"},  64'(get_res(d)), 64'(res));
  endtask

  task automatic drain();
    int n = 0;
    iv32 = 1'b0; iv8 = 1'b0; ordy = 1'b1;
    do begin
      cycle();
      n++;
    end while ((phase[0] != 0 || phase[1] != 0 || phase[2] != 0) && n < 60);
    check("drain_idle", 64'(n < 60), 64'd1);
  endtask

  initial begin
    int t0;
    int n_ov;
    for (int d = 0; d < 3; d++) begin
      phase[d] = 0; mcnt[d] = 0; er[d] = 3'b000;
    end

    // Reset, then release and confirm cleared results.
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    for (int d = 0; d < 3; d++) check($sformatf("reset_res[%0d]", d), 64'(get_res(d)), 64'd0);

    // Unsigned, difference only in the last digit.
    start32(32'h1234_5678, 32'h1234_5679, 1'b0, t0);
    wait_result(0, t0, 5, LT, "t1_lt_last_digit");
    drain();

    // Sign bit decides: unsigned vs signed.
    start32(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, t0);
    wait_result(0, t0, 2, GT, "t2_unsigned");
    drain();
    start32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, t0);
    wait_result(0, t0, 2, LT, "t2_signed");
    drain();

    // Equal operands scan everything; full-scan instance ignores early difference.
    start32(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, t0);
    wait_result(0, t0, 5, EQ, "t3_equal");
    drain();
    start32(32'hFF00_0000, 32'h0000_0000, 1'b0, t0);
    wait_result(1, t0, 5, GT, "t3_full_scan");
    drain();

    // Back-pressure: result held, new operands refused until consumed.
    ordy = 1'b0;
    start32(32'h0000_0001, 32'h0000_0002, 1'b0, t0);
    wait_result(0, t0, 5, LT, "t4_first");
    a32 = 32'h0000_0005; b32 = 32'h0000_0003; sm32 = 1'b0; iv32 = 1'b1;
    repeat (3) begin
      cycle();
      check("t4_hold_valid", 64'(get_ov(0)),  64'd1);
      check("t4_hold_res",   64'(get_res(0)), 64'(LT));
      check("t4_hold_ready", 64'(get_ir(0)),  64'd0);
    end
    ordy = 1'b1;
    cycle();
    check("t4_idle_ready", 64'(get_ir(0)), 64'd1);
    check("t4_idle_valid", 64'(get_ov(0)), 64'd0);
    t0 = cyc;
    cycle();
    iv32 = 1'b0;
    check("t4_pending_busy", 64'(get_busy(0)), 64'd1);
    wait_result(0, t0, 5, GT, "t4_pending");
    drain();

    // Reset during digit 1 of a full scan aborts with no result.
    start32(32'h0000_0000, 32'h0000_0000, 1'b0, t0);
    cycle();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t5_ov[%0d]", d),    64'(get_ov(d)),   64'd0);
      check($sformatf("t5_res[%0d]", d),   64'(get_res(d)),  64'd0);
      check($sformatf("t5_busy[%0d]", d),  64'(get_busy(d)), 64'd0);
      check($sformatf("t5_ready[%0d]", d), 64'(get_ir(d)),   64'd1);
    end
    cycle();
    rst_n = 1'b1;
    n_ov = 0;
    repeat (10) begin
      cycle();
      if (get_ov(0) || get_ov(1)) n_ov++;
    end
    check("t5_no_result", 64'(n_ov), 64'd0);

    // Single-digit signed instance, back-to-back transactions.
    start8(8'hFE, 8'h01, 1'b1, t0);
    a8 = 8'h7F; b8 = 8'h80; sm8 = 1'b1; iv8 = 1'b1;
    wait_result(2, t0, 2, LT, "t6_first");
    cycle();
    check("t6_ready_t3", 64'(get_ir(2)), 64'd1);
    t0 = cyc;
    cycle();
    iv8 = 1'b0;
    check("t6_accept_t3", 64'(t0 - (cyc - 4)), 64'd3);
    check("t6_busy", 64'(get_busy(2)), 64'd1);
    wait_result(2, t0, 2, GT, "t6_second");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/comparator_ds_seq.md
Name: comparator_ds_seq

Overview:
Parametrised, digit-serial magnitude comparator, the multi-cycle successor to the fixed 8-bit combinational comparator. It latches two WIDTH-bit operands through a valid/ready handshake, scans DIGIT bits per cycle from MSB to LSB, and returns one-hot eq/gt/lt through an output handshake. It adds a signed mode and early exit on the first differing digit. It sits in datapaths where wide compares must not sit on the critical path and a variable latency is acceptable.

Parameters:
WIDTH, 32, operand width in bits; must be >= 2.
DIGIT, 8, bits compared per cycle; WIDTH % DIGIT == 0 is required (elaboration-time check).
EARLY_EXIT, 1, 1 = finish on the first differing digit; 0 = always scan all digits (constant latency).

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/mode present
in_ready  out  1  block can accept (= state IDLE)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
signed_mode  in  1  1 = two's-complement compare, 0 = unsigned
out_valid  out  1  result present
out_ready  in  1  consumer takes result
eq  out  1  A == B
gt  out  1  A > B
lt  out  1  A < B
busy  out  1  state != IDLE

Behaviour:
- NDIG = WIDTH/DIGIT. The digit counter is max(1, clog2(NDIG)) bits wide.
- States: IDLE, SCAN, DONE. Reset (async, rst_n=0): state=IDLE, counter=0, eq=gt=lt=0, out_valid=0, busy=0. in_ready=1, because it is decoded from IDLE.
- IDLE: on in_valid && in_ready (cycle T), register a, b and signed_mode, clear the counter, and go to SCAN. Input changes after acceptance are ignored.
- Signed mode: invert bit WIDTH-1 of both latched operands (offset-binary transform), then compare unsigned.
- SCAN: each cycle compare digit k (k=0 is the MSB digit, bits WIDTH-1-k*DIGIT downto WIDTH-(k+1)*DIGIT) with MSB-priority logic.
  - If the digit differs and no difference has been recorded yet, record gt/lt.
  - EARLY_EXIT=1: go to DONE on the first difference, or after digit NDIG-1.
  - EARLY_EXIT=0: always go to DONE after digit NDIG-1. Later digits never override the first recorded difference.
  - No difference after all digits: eq=1.
- Latency: out_valid rises in cycle T+1+m, where m = number of digits examined (1..NDIG). With EARLY_EXIT=0, m=NDIG always.
- DONE: out_valid=1 and exactly one of eq/gt/lt is 1. Outputs are held stable while out_ready=0. in_ready=0, so no overlap with a new transaction.
  - On out_ready=1: go to IDLE and drop out_valid the next cycle. eq/gt/lt hold their value until the next result is written.
  - A new input can be accepted in the cycle after the output handshake.
- out_valid=1 implies eq|gt|lt is one-hot. eq/gt/lt are don't-care to the consumer when out_valid=0.
- rst_n low mid-SCAN or mid-DONE aborts the transaction, restores the reset values, and discards the result.
- WIDTH == DIGIT (NDIG=1): a single SCAN cycle, latency 2.

Decomposition:
- Shared package comparator_pkg holds:
  - state enum {IDLE, SCAN, DONE}
  - a function returning NDIG
  - a function returning the counter width
  - the result encoding constants.
- One combinational sub-module, cmp_digit (parameter DIGIT; inputs da, db; outputs d_eq, d_gt), built as a prefix-equality / priority-greater chain. Top-level d_lt = ~d_eq & ~d_gt.
- The top level holds the FSM, operand registers, digit mux/shift and result registers.

Test Plan:
1. WIDTH=32, DIGIT=8, unsigned, a=0x12345678, b=0x12345679, accepted at T -> lt=1, eq=gt=0, out_valid at T+5 (m=4).
2. a=0x80000000, b=0x7FFFFFFF. With signed_mode=0 -> gt=1 at T+2. Repeat with signed_mode=1 -> lt=1 at T+2.
3. a=b=0xDEADBEEF -> eq=1 at T+5. Then with EARLY_EXIT=0, a=0xFF000000, b=0x00000000 -> gt=1 at T+5 (not T+2).
4. Hold out_ready=0 for 3 cycles with in_valid=1 and new operands -> out_valid, eq/gt/lt and in_ready=0 stay stable, nothing is accepted. Then set out_ready=1 -> IDLE next cycle and the pending input is accepted one cycle later.
5. Pulse rst_n=0 during SCAN of digit 1 -> out_valid=0, eq=gt=lt=0, busy=0, in_ready=1 immediately. No result appears after release.
6. WIDTH=8, DIGIT=8, signed_mode=1, a=0xFE (-2), b=0x01 -> lt=1 at T+2. Back-to-back with out_ready=1: the next pair is accepted at T+3.
